// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch front end. Issues word-address requests to an
// in-order instruction memory, queues returned words tagged with their PC, and
// presents the queue head to the decoder. Redirects flush the queue. Responses
// that belong to the abandoned path are counted out and dropped.
//
// Optional feature macro: FETCH_ECALL_HALT_EN. When defined, fetch halts after
// an ECALL word (32'h0000_0073) is queued. Fetch resumes on redirect or reset.
//
// Handshake rule for every port pair: a transfer happens in a cycle where both
// valid and ready are high at the rising edge. imem_req_valid never depends on
// imem_req_ready, and out_valid never depends on out_ready. imem_rsp_valid has
// no ready: the credit check guarantees that queue space is always available.
module fetch_buffer #(
    parameter int          DEPTH       = 4,
    parameter int          IMEM_ADDR_W = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [IMEM_ADDR_W-1:0] imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc_plus4,
    output logic                   out_ecall,
    output logic                   halted
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW         = $clog2(DEPTH + 1);
    localparam int          SW         = CW + 1;
    localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);
    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    logic [31:0]   fpc;
    logic [31:0]   rpc;
    logic [CW-1:0] occ;
    logic [CW-1:0] outs;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic [SW-1:0] credit_sum;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [CW-1:0] outs_after_rsp;

    // Credit accounting, handshake qualification and head-of-queue outputs.
    always_comb begin
        credit_sum     = SW'(occ) + SW'(outs);
        imem_req_valid = !rst && !halted && !redirect_valid && (credit_sum < DEPTH_SUM);
        imem_req_addr  = fpc[IMEM_ADDR_W+1:2];
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is stale (pre-reset) and ignored.
        rsp_take       = !rst && imem_rsp_valid && (outs != '0);
        rsp_drop       = rsp_take && (drop_cnt != '0);
        push           = rsp_take && !rsp_drop && !redirect_valid;
        outs_after_rsp = outs - CW'(rsp_take);
        out_valid      = !rst && (occ != '0);
        pop            = out_valid && out_ready && !redirect_valid;
        out_instr      = q_instr[rd_ptr];
        out_pc         = q_pc[rd_ptr];
        out_pc_plus4   = out_pc + 32'd4;
        out_ecall      = out_valid && (out_instr == ECALL_WORD);
    end

    // Fetch/response PCs, queue pointers and in-flight bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc      <= RESET_PC;
            rpc      <= RESET_PC;
            occ      <= '0;
            outs     <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight belongs to the old path. This
            // includes requests already marked for dropping.
            fpc      <= redirect_pc;
            rpc      <= redirect_pc;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            outs     <= outs_after_rsp;
            drop_cnt <= outs_after_rsp;
        end else begin
            if (req_fire) begin
                fpc <= fpc + 32'd4;
            end
            outs <= outs + CW'(req_fire) - CW'(rsp_take);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (push) begin
                rpc    <= rpc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // Queue storage: no reset needed, contents are qualified by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]    <= rpc;
        end
    end

`ifdef FETCH_ECALL_HALT_EN
    // Halt request issue once an ECALL word lands in the queue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            halted <= 1'b0;
        end else if (push && (imem_rsp_data == ECALL_WORD)) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks of fetch_buffer against an
// in-order memory model and a sequential-fetch stream model.
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          AW       = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc_plus4;
    logic          out_ecall;
    logic          halted;

    fetch_buffer #(.DEPTH(DEPTH), .IMEM_ADDR_W(AW), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .out_ecall      (out_ecall),
        .halted         (halted)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Memory model: pending word addresses in request order.
    logic [AW-1:0] pend_q[$];
    logic          rsp_en;
    int            rsp_pct, rdy_pct, out_pct;
    logic          ecall_on;
    logic [AW-1:0] ecall_wa;
    logic          flush_late;

    // Stream model: next PC the consumer must see, next PC to be requested.
    logic [31:0] exp_pc, exp_req_pc;

    // Per-window statistics and negedge snapshots.
    int          req_cnt, pop_cnt, ecall_pops, cyc, first_out_cyc;
    logic [31:0] first_pop_pc, wrap_plus4;
    logic        prev_stall;
    logic [31:0] prev_instr, prev_pc;
    logic        s_req_valid, s_out_valid, s_out_ecall, s_halted;
    logic [AW-1:0] s_req_addr;
    logic [31:0] s_out_pc;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] wa);
        if (ecall_on && wa == ecall_wa) return 32'h0000_0073;
        return {wa ^ 16'hA5A5, ~wa};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic win();
        req_cnt    = 0;
        pop_cnt    = 0;
        ecall_pops = 0;
    endtask

    // One clock cycle: drive inputs, check at negedge, update models at posedge.
    task automatic tick();
        logic          rsp_now, req_acc, pop_now;
        logic [AW-1:0] acc_addr;
        rsp_now = 1'b0;
        if (rsp_en && pend_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0]);
            rsp_now        = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < out_pct);
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_ecall = out_ecall;
        s_out_pc    = out_pc;
        s_halted    = halted;
        req_acc  = !rst && imem_req_valid && imem_req_ready;
        pop_now  = !rst && out_valid && out_ready && !redirect_valid;
        acc_addr = imem_req_addr;
        if (req_acc) begin
            check("req_addr", 32'(imem_req_addr), 32'(exp_req_pc[AW+1:2]));
            req_cnt++;
        end
        if (!rst && prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_instr", out_instr, prev_instr);
            check("hold_pc", out_pc, prev_pc);
        end
        prev_stall = !rst && out_valid && !out_ready && !redirect_valid;
        prev_instr = out_instr;
        prev_pc    = out_pc;
        if (pop_now) begin
            check("out_pc", out_pc, exp_pc);
            check("out_instr", out_instr, mem_word(exp_pc[AW+1:2]));
            check("out_pc_plus4", out_pc_plus4, exp_pc + 32'd4);
            check("out_ecall", 32'(out_ecall), 32'(mem_word(exp_pc[AW+1:2]) == 32'h0000_0073));
            if (pop_cnt == 0) first_pop_pc = out_pc;
            pop_cnt++;
            if (out_ecall) ecall_pops++;
            if (exp_pc == 32'hFFFF_FFFC) wrap_plus4 = out_pc_plus4;
            exp_pc = exp_pc + 32'd4;
        end
        if (!rst && out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        @(posedge clk);
        if (rsp_now) void'(pend_q.pop_front());
        if (flush_late) begin
            pend_q.delete();
            flush_late = 1'b0;
        end
        if (req_acc) begin
            pend_q.push_back(acc_addr);
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (!rst && redirect_valid) begin
            exp_pc     = redirect_pc;
            exp_req_pc = redirect_pc;
        end
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        exp_pc        = RESET_PC;
        exp_req_pc    = RESET_PC;
        cyc           = 0;
        first_out_cyc = -1;
        prev_stall    = 1'b0;
        win();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        rsp_en         = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        pend_q.delete();
        model_reset();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        rsp_en = 1'b0; rsp_pct = 100; rdy_pct = 100; out_pct = 100;
        ecall_on = 1'b0; ecall_wa = '0; flush_late = 1'b0; wrap_plus4 = 32'hDEAD_BEEF;
        first_pop_pc = '0;
        model_reset();
        @(posedge clk); #1;

        // Reset values.
        do_reset();
        check("rst_req_valid", 32'(s_req_valid), 32'd0);
        check("rst_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_out_ecall", 32'(s_out_ecall), 32'd0);

        // Streaming, 1-cycle memory, consumer always ready.
        rsp_en = 1'b1; rsp_pct = 100; rdy_pct = 100; out_pct = 100;
        tick();
        check("first_req_valid", 32'(s_req_valid), 32'd1);
        check("first_req_addr", 32'(s_req_addr), 32'd0);
        check("halted_after_rst", 32'(s_halted), 32'd0);
        repeat (19) tick();
        check("stream_req_cnt", 32'(req_cnt), 32'd20);
        check("stream_pop_cnt", 32'(pop_cnt), 32'd18);
        check("first_out_latency", 32'(first_out_cyc), 32'd2);

        // Consumer stalled: credit stops issue at DEPTH requests.
        do_reset();
        rsp_en = 1'b1; out_pct = 0;
        repeat (10) tick();
        check("stall_req_cnt", 32'(req_cnt), DEPTH);
        check("stall_req_valid", 32'(s_req_valid), 32'd0);
        check("stall_out_valid", 32'(s_out_valid), 32'd1);
        check("stall_out_pc", s_out_pc, RESET_PC);
        out_pct = 100;
        repeat (10) tick();

        // Redirect with two requests outstanding.
        do_reset();
        rsp_en = 1'b0;
        repeat (2) tick();
        check("pre_redir_req_cnt", 32'(req_cnt), 32'd2);
        do_redirect(32'h0000_0100);
        rsp_en = 1'b1;
        win();
        tick();
        check("redir_req_valid", 32'(s_req_valid), 32'd1);
        check("redir_req_addr", 32'(s_req_addr), 32'h0000_0040);
        repeat (10) tick();
        check("redir_first_pc", first_pop_pc, 32'h0000_0100);

        // PC wrap at the top of the address space.
        do_redirect(32'hFFFF_FFF8);
        win();
        repeat (10) tick();
        check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);
        check("wrap_plus4", wrap_plus4, 32'h0000_0000);

        // ECALL at PC 12.
        do_reset();
        ecall_on = 1'b1; ecall_wa = 16'd3; rsp_en = 1'b1;
        repeat (10) tick();
        check("ecall_pops", 32'(ecall_pops), 32'd1);
`ifdef FETCH_ECALL_HALT_EN
        check("ecall_halted", 32'(s_halted), 32'd1);
        check("ecall_req_valid", 32'(s_req_valid), 32'd0);
        check("ecall_req_cnt", 32'(req_cnt), 32'd5);
`else
        check("ecall_halted", 32'(s_halted), 32'd0);
        check("ecall_req_cnt", 32'(req_cnt), 32'd10);
`endif
        do_redirect(32'h0000_0200);
        ecall_on = 1'b0;
        win();
        repeat (6) tick();
        check("resume_halted", 32'(s_halted), 32'd0);
        check("resume_req_cnt", 32'(req_cnt), 32'd6);
        check("resume_first_pc", first_pop_pc, 32'h0000_0200);

        // Reset with three requests outstanding and a non-empty queue.
        do_reset();
        out_pct = 0;
        rsp_en = 1'b0; tick();
        rsp_en = 1'b1; tick();
        rsp_en = 1'b0; tick(); tick(); tick();
        check("prerst_req_cnt", 32'(req_cnt), 32'd4);
        check("prerst_req_valid", 32'(s_req_valid), 32'd0);
        check("prerst_out_valid", 32'(s_out_valid), 32'd1);
        rsp_en = 1'b1; rst = 1'b1;
        tick();
        check("inrst_req_valid", 32'(s_req_valid), 32'd0);
        check("inrst_out_valid", 32'(s_out_valid), 32'd0);
        check("inrst_out_ecall", 32'(s_out_ecall), 32'd0);
        rst = 1'b0;
        model_reset();
        flush_late = 1'b1;
        out_pct = 100;
        tick();
        check("postrst_out_valid", 32'(s_out_valid), 32'd0);
        check("postrst_req_addr", 32'(s_req_addr), 32'd0);
        repeat (10) tick();
        check("postrst_first_pc", first_pop_pc, RESET_PC);

        // Randomized traffic with random redirects.
        do_reset();
        rsp_en = 1'b1; rsp_pct = 60; rdy_pct = 60; out_pct = 60;
        for (int i = 0; i < 400; i++) begin
            redirect_valid = ($urandom_range(99) < 6);
            redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            tick();
        end
        redirect_valid = 1'b0;
        rsp_pct = 100; rdy_pct = 100; out_pct = 100;
        repeat (20) tick();
        check("rand_pops_seen", 32'(pop_cnt > 50), 32'd1);
        check("rand_halted", 32'(s_halted), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
